// File: rtl/vc_port_pkg.sv
// vc_port_pkg: shared flit geometry, header codes and header decode helper
package vc_port_pkg;
    localparam int FLIT_SIZE = 32;
    localparam int HEADER_LEN = 2;
    localparam int ROUTE_LEN = 3;
    typedef enum logic [HEADER_LEN-1:0] {
        HDR_HEAD   = 2'd0,
        HDR_BODY   = 2'd1,
        HDR_TAIL   = 2'd2,
        HDR_SINGLE = 2'd3
    } flit_type_t;
    function automatic flit_type_t flit_type(input logic [FLIT_SIZE-1:0] f);
        return flit_type_t'(f[FLIT_SIZE-1 -: HEADER_LEN]);
    endfunction
endpackage

// File: rtl/vc_port_if.sv
// vc_port_if: input-port bundle (flit write, ovc request/grant, credits, switch output, status); master drives inputs, slave is the port
interface vc_port_if #(parameter int NUM_VC = 4, parameter int OVC_W = 4);
    import vc_port_pkg::*;
    localparam int VCW = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
    logic [FLIT_SIZE-1:0] flit_in;
    logic valid_in;
    logic [VCW-1:0] vc_in;
    logic [ROUTE_LEN-1:0] route_in;
    logic [NUM_VC-1:0] ovc_req;
    logic [NUM_VC*ROUTE_LEN-1:0] ovc_req_route;
    logic [NUM_VC-1:0] ovc_grant;
    logic [OVC_W-1:0] ovc_grant_id;
    logic [NUM_VC-1:0] credit_ok;
    logic out_ready;
    logic [FLIT_SIZE-1:0] flit_out;
    logic valid_out;
    logic [VCW-1:0] out_vc;
    logic [ROUTE_LEN-1:0] out_route;
    logic [OVC_W-1:0] out_ovc;
    logic [NUM_VC-1:0] credit_out;
    logic [NUM_VC-1:0] vc_idle;
    logic [NUM_VC-1:0] vc_full;
    logic [NUM_VC-1:0] overflow_err;
    modport master (
        output flit_in, valid_in, vc_in, route_in, ovc_grant, ovc_grant_id, credit_ok, out_ready,
        input ovc_req, ovc_req_route, flit_out, valid_out, out_vc, out_route, out_ovc, credit_out,
        input vc_idle, vc_full, overflow_err
    );
    modport slave (
        input flit_in, valid_in, vc_in, route_in, ovc_grant, ovc_grant_id, credit_ok, out_ready,
        output ovc_req, ovc_req_route, flit_out, valid_out, out_vc, out_route, out_ovc, credit_out,
        output vc_idle, vc_full, overflow_err
    );
endinterface

// File: rtl/vc_port_buffer.sv
// vc_port_buffer: per-VC FIFO (clk, rst active-low sync, wr_en/wr_data, rd_en/rd_data front, empty, full, count)
module vc_port_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic empty,
    output logic full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign rd_data = mem[rp];
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(wr_ok);
            rp <= rp + AW'(rd_ok);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
endmodule

// File: rtl/vc_port.sv
// vc_port: router input port with per-VC FIFOs, per-VC ovc/credit FSMs and round-robin switch arbiter (clk, rst active-low sync, bus slave)
module vc_port import vc_port_pkg::*; #(
    parameter int NUM_VC = 4,
    parameter int VC_DEPTH = 16,
    parameter int OVC_W = 4
) (
    input logic clk,
    input logic rst,
    vc_port_if.slave bus
);
    localparam int VCW = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
    localparam int AW = $clog2(VC_DEPTH);
    localparam int DW = ROUTE_LEN + FLIT_SIZE;
    typedef enum logic [1:0] {IDLE, WAIT_OVC, ACTIVE, WAIT_CREDITS} vc_state_t;
    vc_state_t st_q [NUM_VC];
    vc_state_t st_d [NUM_VC];
    logic [OVC_W-1:0] ovc_q [NUM_VC];
    logic [OVC_W-1:0] ovc_d [NUM_VC];
    logic [DW-1:0] front [NUM_VC];
    logic [AW:0] cnt [NUM_VC];
    logic [NUM_VC-1:0] empty, full, wr_en, rd_en, deq, elig, is_start, is_end, err_q, err_d;
    logic [VCW-1:0] ptr_q, win, idx;
    logic any, fire;
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        flit_type_t t;
        vc_port_buffer #(.WIDTH(DW), .DEPTH(VC_DEPTH)) u_buf (
            .clk(clk),
            .rst(rst),
            .wr_en(wr_en[v]),
            .wr_data({bus.route_in, bus.flit_in}),
            .rd_en(rd_en[v]),
            .rd_data(front[v]),
            .empty(empty[v]),
            .full(full[v]),
            .count(cnt[v])
        );
        assign t = flit_type(front[v][FLIT_SIZE-1:0]);
        assign is_start[v] = t == HDR_HEAD || t == HDR_SINGLE;
        assign is_end[v] = t == HDR_TAIL || t == HDR_SINGLE;
        assign wr_en[v] = bus.valid_in && bus.vc_in == VCW'(v);
        assign elig[v] = st_q[v] == ACTIVE && !empty[v] && bus.credit_ok[v];
        assign deq[v] = fire && win == VCW'(v);
        assign bus.ovc_req[v] = st_q[v] == WAIT_OVC;
        assign bus.ovc_req_route[v*ROUTE_LEN +: ROUTE_LEN] = front[v][DW-1 -: ROUTE_LEN];
        assign bus.vc_idle[v] = st_q[v] == IDLE && empty[v];
    end
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            idx = VCW'((int'(ptr_q) + k) % NUM_VC);
            if (elig[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    // gating with rst keeps the port silent and credit-free during a reset cycle
    assign fire = rst && any && bus.out_ready;
    assign bus.valid_out = rst && any;
    assign bus.flit_out = front[win][FLIT_SIZE-1:0];
    assign bus.out_route = front[win][DW-1 -: ROUTE_LEN];
    assign bus.out_vc = win;
    assign bus.out_ovc = ovc_q[win];
    assign bus.credit_out = deq;
    assign bus.vc_full = full;
    assign bus.overflow_err = err_q;
    always_comb begin
        err_d = err_q | (wr_en & full);
        rd_en = deq;
        for (int i = 0; i < NUM_VC; i++) begin
            st_d[i] = st_q[i];
            ovc_d[i] = ovc_q[i];
            case (st_q[i])
                IDLE: if (!empty[i]) begin
                    if (is_start[i]) st_d[i] = WAIT_OVC;
                    else begin
                        rd_en[i] = 1'b1;
                        err_d[i] = 1'b1;
                    end
                end
                WAIT_OVC: if (bus.ovc_grant[i]) begin
                    st_d[i] = ACTIVE;
                    ovc_d[i] = bus.ovc_grant_id;
                end
                ACTIVE: if (deq[i] && is_end[i]) begin
                    st_d[i] = cnt[i] > (AW+1)'(1) ? WAIT_OVC : IDLE;
                    ovc_d[i] = '1;
                end else if (!bus.credit_ok[i]) st_d[i] = WAIT_CREDITS;
                default: if (bus.credit_ok[i]) st_d[i] = ACTIVE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            err_q <= '0;
            for (int i = 0; i < NUM_VC; i++) begin
                st_q[i] <= IDLE;
                ovc_q[i] <= '1;
            end
        end else begin
            if (fire) ptr_q <= win == VCW'(NUM_VC - 1) ? '0 : win + VCW'(1);
            err_q <= err_d;
            for (int i = 0; i < NUM_VC; i++) begin
                st_q[i] <= st_d[i];
                ovc_q[i] <= ovc_d[i];
            end
        end
    end
endmodule

// File: doc/vc_port.md
VC_PORT -- requirements
Module: vc_port

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, number of virtual channels in the port.
REQ-002 SHALL have parameter VC_DEPTH, default 16, flit slots per VC (power of two, >=2).
REQ-003 SHALL have parameter OVC_W, default 4, width of the assigned output-VC identifier.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port flit_in  in  FLIT_SIZE  incoming flit, header field in the top HEADER_LEN bits.
REQ-007 SHALL have port valid_in  in  1  flit_in/vc_in/route_in valid this cycle.
REQ-008 SHALL have port vc_in  in  clog2(NUM_VC)  target VC of the incoming flit.
REQ-009 SHALL have port route_in  in  ROUTE_LEN  output port of the incoming flit.
REQ-010 SHALL have port ovc_req  out  NUM_VC  VC i is in WAIT_OVC.
REQ-011 SHALL have port ovc_req_route  out  NUM_VC*ROUTE_LEN  route of the front flit of each VC.
REQ-012 SHALL have port ovc_grant  in  NUM_VC  output-VC allocation granted to VC i.
REQ-013 SHALL have port ovc_grant_id  in  OVC_W  output VC assigned with any ovc_grant bit.
REQ-014 SHALL have port credit_ok  in  NUM_VC  downstream VC held by VC i has at least one credit.
REQ-015 SHALL have port out_ready  in  1  switch accepts flit_out this cycle.
REQ-016 SHALL have port flit_out  out  FLIT_SIZE  selected flit.
REQ-017 SHALL have port valid_out  out  1  flit_out valid.
REQ-018 SHALL have ports out_vc  out  clog2(NUM_VC)  source VC; out_route  out  ROUTE_LEN; out_ovc  out  OVC_W.
REQ-019 SHALL have port credit_out  out  NUM_VC  one-cycle pulse per flit dequeued from VC i (upstream credit return).
REQ-020 SHALL have ports vc_idle  out  NUM_VC, vc_full  out  NUM_VC, overflow_err  out  NUM_VC (sticky).

Function
REQ-021 Each VC SHALL hold a FIFO of {route, flit}; a write becomes visible at the front on the next cycle.
REQ-022 A write to VC v SHALL be accepted when valid_in=1 and VC v is not full at cycle start; otherwise it is dropped and overflow_err[v] is set until reset, even with a same-cycle dequeue.
REQ-023 Simultaneous write and dequeue on one non-full VC SHALL leave its occupancy unchanged.
REQ-024 Per-VC states SHALL be IDLE, WAIT_OVC, ACTIVE, WAIT_CREDITS.
REQ-025 IDLE->WAIT_OVC SHALL occur when the FIFO front is HEAD or SINGLE.
REQ-026 If the front is BODY or TAIL in IDLE, the flit SHALL be discarded (one per cycle) and overflow_err set.
REQ-027 WAIT_OVC->ACTIVE SHALL occur on ovc_grant[i]; the VC latches ovc_grant_id into its O register.
REQ-028 ACTIVE->WAIT_CREDITS SHALL occur when credit_ok[i]=0; WAIT_CREDITS->ACTIVE when credit_ok[i]=1.
REQ-029 On dequeue of a TAIL or SINGLE, the VC SHALL go to WAIT_OVC if another flit remains, else IDLE, and O returns to all-ones.
REQ-030 A VC SHALL be eligible when ACTIVE, non-empty and credit_ok[i]=1.
REQ-031 The arbiter SHALL pick one eligible VC round-robin; valid_out=1 iff any is eligible; outputs are combinational from registered state.
REQ-032 The arbiter SHALL dequeue only when valid_out && out_ready, pulse credit_out[winner] that cycle, and set the pointer to winner+1 mod NUM_VC.
REQ-033 With out_ready=0, the selection SHALL hold and the pointer SHALL not move.
REQ-034 vc_idle[i] SHALL equal (state==IDLE and FIFO empty); vc_full[i] SHALL equal occupancy==VC_DEPTH.

Reset
REQ-035 While rst=0 at a clock edge: all FIFOs empty, states IDLE, O all-ones, pointer 0, overflow_err 0, credit_out 0, valid_out 0.
REQ-036 Reset mid-packet SHALL discard all buffered flits with no credit_out pulses.

Structure
REQ-037 The shared package SHALL hold FLIT_SIZE, HEADER_LEN, ROUTE_LEN and the HEAD/BODY/TAIL/SINGLE codes; the vc_state enum SHALL be local to this module.
REQ-038 Each VC FIFO SHALL be an instance of the existing buffer sub-module (depth VC_DEPTH); arbiter and FSMs SHALL be in this module.

Verification
REQ-039 Write SINGLE to VC2, route 3; grant with id 5 two cycles later -> ACTIVE, out_vc=2, out_route=3, out_ovc=5, credit_out[2] pulse, then IDLE.
REQ-040 VC0 and VC1 each hold a 3-flit packet, both granted, out_ready=1 -> output order VC0,VC1,VC0,VC1,VC0,VC1.
REQ-041 VC1 ACTIVE, credit_ok[1]=0 for 4 cycles -> WAIT_CREDITS, no dequeue, resumes one cycle after credit_ok returns.
REQ-042 Write 17 flits to VC3 (depth 16) without dequeue -> vc_full[3]=1, 17th flit dropped, overflow_err[3]=1.
REQ-043 TAIL then HEAD queued in VC0 -> after TAIL dequeue VC0 in WAIT_OVC, O=all-ones.
REQ-044 Assert rst=0 mid-packet -> next cycle all vc_idle=1, valid_out=0.
